// File: rtl/rv32_multicycle_lsu_if.sv
// Bundles the core-side request/response and memory-side transaction
// signals of the load/store unit.
//   slave  : the LSU (takes requests and read data, drives responses and memory requests)
//   master : the environment (core FSM plus memory)
//   req_*  : core request channel       resp_* : completion pulse, data, error
//   mem_*  : word-aligned memory transaction with byte strobes and ack
interface rv32_multicycle_lsu_if #(
  parameter int unsigned XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wr_data;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_data;
  logic              resp_error;
  logic              mem_req;
  logic [XLEN-1:0]   mem_addr;
  logic              mem_wr_ena;
  logic [XLEN-1:0]   mem_wr_data;
  logic [XLEN/8-1:0] mem_wr_strb;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rd_data;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wr_data, mem_ack, mem_rd_data,
    output req_ready, resp_valid, resp_data, resp_error,
           mem_req, mem_addr, mem_wr_ena, mem_wr_data, mem_wr_strb
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wr_data, mem_ack, mem_rd_data,
    input  req_ready, resp_valid, resp_data, resp_error,
           mem_req, mem_addr, mem_wr_ena, mem_wr_data, mem_wr_strb
  );
endinterface

// File: rtl/rv32_multicycle_lsu.sv
// Load/store unit between the multicycle core FSM and a variable-latency
// memory. Decodes RISC-V funct3 size/sign, runs req/ack transactions with
// byte strobes, splits word-crossing accesses into two aligned words and
// aligns/extends load data. A missing ack aborts with an error.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   ena  : 0 freezes FSM, timeout counter and outputs
//   bus  : request/response and memory channels (slave side)
module rv32_multicycle_lsu #(
  parameter int unsigned XLEN             = 32,
  parameter bit          SPLIT_MISALIGNED = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  rv32_multicycle_lsu_if.slave bus
);
  localparam int unsigned W  = XLEN / 8;
  localparam int unsigned OW = $clog2(W);

  typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP, S_ERR} state_t;

  function automatic logic f3_ok(input logic [2:0] f);
    case (f)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
      3'b011, 3'b110:                         f3_ok = (XLEN == 64);
      default:                                f3_ok = 1'b0;
    endcase
  endfunction

  function automatic logic crosses(input logic [OW-1:0] off, input logic [1:0] sz);
    crosses = (32'(off) + (32'd1 << sz)) > W;
  endfunction

  state_t          r_state, w_next;
  logic            r_write;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_addr, r_wr_data, r_lo, r_hi;
  logic            r_mem_req;
  logic [31:0]     r_tmo;

  logic [OW-1:0]     w_off;
  logic [1:0]        w_sz;
  logic              w_cross, w_ack, w_tmo;
  logic [XLEN-1:0]   w_word, w_sh, w_msk, w_ld;
  logic              w_sb;
  logic [2*W-1:0]    w_mask2;
  logic [2*XLEN-1:0] w_wd2;

  assign w_off   = r_addr[OW-1:0];
  assign w_sz    = r_f3[1:0];
  assign w_cross = crosses(w_off, w_sz);
  assign w_word  = {r_addr[XLEN-1:OW], {OW{1'b0}}};
  assign w_ack   = r_mem_req & bus.mem_ack;
  assign w_tmo   = (TIMEOUT_CYCLES != 0) && r_mem_req && !bus.mem_ack &&
                   (r_tmo == TIMEOUT_CYCLES - 1);

  // Byte mask and store data shifted across a double word: the low half
  // feeds the first transaction, the high half the second.
  always_comb begin
    w_mask2 = '0;
    for (int unsigned i = 0; i < 2 * W; i++)
      w_mask2[i] = (i >= 32'(w_off)) && (i < 32'(w_off) + (32'd1 << w_sz));
    w_wd2 = {{XLEN{1'b0}}, r_wr_data} << {w_off, 3'b000};
    w_sh  = XLEN'({r_hi, r_lo} >> {w_off, 3'b000});
    w_msk = '0;
    w_sb  = 1'b0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      w_msk[i] = (i < (32'd8 << w_sz));
      if (i == (32'd8 << w_sz) - 32'd1) w_sb = w_sh[i];
    end
    w_ld = (w_sh & w_msk) | ((!r_f3[2] && w_sb) ? ~w_msk : '0);
  end

  always_comb begin
    w_next          = r_state;
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_error  = 1'b0;
    bus.resp_data   = '0;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    bus.mem_wr_strb = '0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = ena & ~rst;
        if (bus.req_valid) begin
          if (!f3_ok(bus.req_funct3) ||
              (!SPLIT_MISALIGNED && crosses(bus.req_addr[OW-1:0], bus.req_funct3[1:0])))
            w_next = S_ERR;
          else
            w_next = S_ACC0;
        end
      end
      S_ACC0: begin
        bus.mem_addr = w_word;
        if (r_write) begin
          bus.mem_wr_data = w_wd2[XLEN-1:0];
          bus.mem_wr_strb = w_mask2[W-1:0];
        end
        if (w_ack)      w_next = w_cross ? S_ACC1 : S_RESP;
        else if (w_tmo) w_next = S_ERR;
      end
      S_ACC1: begin
        bus.mem_addr = w_word + XLEN'(W);
        if (r_write) begin
          bus.mem_wr_data = w_wd2[2*XLEN-1:XLEN];
          bus.mem_wr_strb = w_mask2[2*W-1:W];
        end
        if (w_ack)      w_next = S_RESP;
        else if (w_tmo) w_next = S_ERR;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        if (!r_write) bus.resp_data = w_ld;
        w_next = S_IDLE;
      end
      S_ERR: begin
        bus.resp_valid = 1'b1;
        bus.resp_error = 1'b1;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.mem_req    = r_mem_req;
  assign bus.mem_wr_ena = r_mem_req & r_write;

  // mem_req is a register so it falls on the ack edge; ACC1 raises it
  // again one cycle later, giving the mandatory idle cycle between halves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_write   <= 1'b0;
      r_f3      <= '0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_mem_req <= 1'b0;
      r_tmo     <= '0;
    end else if (ena) begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (bus.req_valid) begin
          r_write   <= bus.req_write;
          r_f3      <= bus.req_funct3;
          r_addr    <= bus.req_addr;
          r_wr_data <= bus.req_wr_data;
          r_tmo     <= '0;
          r_mem_req <= (w_next == S_ACC0);
        end
        S_ACC0, S_ACC1: begin
          if (w_ack) begin
            if (r_state == S_ACC0) r_lo <= bus.mem_rd_data;
            else                   r_hi <= bus.mem_rd_data;
            r_mem_req <= 1'b0;
            r_tmo     <= '0;
          end else if (w_tmo) begin
            r_mem_req <= 1'b0;
          end else if (!r_mem_req) begin
            r_mem_req <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32_multicycle_lsu.sv
module tb_rv32_multicycle_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  always #5 clk = ~clk;

  rv32_multicycle_lsu_if #(.XLEN(32)) bus0 ();
  rv32_multicycle_lsu_if #(.XLEN(32)) bus1 ();
  rv32_multicycle_lsu_if #(.XLEN(64)) bus2 ();

  rv32_multicycle_lsu #(.XLEN(32), .SPLIT_MISALIGNED(1'b1), .TIMEOUT_CYCLES(16))
    u_dut0 (.clk(clk), .rst(rst), .ena(ena), .bus(bus0));
  rv32_multicycle_lsu #(.XLEN(32), .SPLIT_MISALIGNED(1'b0), .TIMEOUT_CYCLES(16))
    u_dut1 (.clk(clk), .rst(rst), .ena(ena), .bus(bus1));
  rv32_multicycle_lsu #(.XLEN(64), .SPLIT_MISALIGNED(1'b1), .TIMEOUT_CYCLES(16))
    u_dut2 (.clk(clk), .rst(rst), .ena(ena), .bus(bus2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory model for instance 0: 16 words from 0x100, random ack latency.
  typedef struct { logic [31:0] addr; logic [3:0] strb; logic wr; } tx_t;
  logic [31:0] mem [16];
  tx_t         log_q [$];
  logic        auto_mem = 1'b1, lat0 = 1'b0, a_ack = 1'b0, m_ack = 1'b0;
  logic [31:0] a_rd = '0, m_rd = '0;
  int          cnt = 0;
  int          idx;

  assign bus0.mem_ack     = auto_mem ? a_ack : m_ack;
  assign bus0.mem_rd_data = auto_mem ? a_rd  : m_rd;

  always @(negedge clk) begin
    if (!auto_mem || !bus0.mem_req) begin
      a_ack = 1'b0;
      cnt   = lat0 ? 0 : int'($urandom_range(0, 3));
    end else if (!a_ack) begin
      if (cnt == 0) begin
        idx   = int'((bus0.mem_addr >> 2) & 32'hF);
        a_rd  = mem[idx];
        a_ack = 1'b1;
        if (bus0.mem_wr_ena)
          for (int i = 0; i < 4; i++)
            if (bus0.mem_wr_strb[i]) mem[idx][8*i +: 8] = bus0.mem_wr_data[8*i +: 8];
        log_q.push_back('{addr: bus0.mem_addr, strb: bus0.mem_wr_strb, wr: bus0.mem_wr_ena});
      end else begin
        cnt--;
      end
    end
  end

  logic saw1 = 1'b0;
  always @(negedge clk) if (bus1.mem_req === 1'b1) saw1 = 1'b1;

  // Called on a negedge; returns on the negedge after the response.
  task automatic req0(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] d, output logic e, output int lat, output logic [15:0] hist);
    int k = 0;
    hist = '0;
    while (!bus0.req_ready && k < 20) begin @(negedge clk); k++; end
    bus0.req_valid = 1'b1; bus0.req_write = wr; bus0.req_funct3 = f3;
    bus0.req_addr = a; bus0.req_wr_data = wd;
    @(negedge clk);
    bus0.req_valid = 1'b0;
    lat = 1;
    hist[1] = bus0.mem_req;
    while (!bus0.resp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat < 16) hist[lat] = bus0.mem_req;
    end
    d = bus0.resp_data;
    e = bus0.resp_error;
    if (!bus0.resp_valid) lat = -1;
    @(negedge clk);
  endtask

  typedef struct {
    logic wr; logic [2:0] f3; logic [31:0] addr; logic [31:0] wd;
    logic [31:0] exp_d; logic exp_e; int ntx; logic [3:0] s0; logic [3:0] s1;
  } vec_t;
  vec_t vecs [18];

  logic [31:0] d;
  logic        e;
  int          lat;
  logic [15:0] hist;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 32'h87654321;
    mem[1] = 32'hCAFEBABE;
    vecs[0]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'hFFFFFF87, 1'b0, 1, 4'h0, 4'h0};
    vecs[1]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h00000087, 1'b0, 1, 4'h0, 4'h0};
    vecs[2]  = '{1'b0, 3'b001, 32'h100, 32'h0,        32'h00004321, 1'b0, 1, 4'h0, 4'h0};
    vecs[3]  = '{1'b0, 3'b101, 32'h103, 32'h0,        32'h0000BE87, 1'b0, 2, 4'h0, 4'h0};
    vecs[4]  = '{1'b0, 3'b001, 32'h103, 32'h0,        32'hFFFFBE87, 1'b0, 2, 4'h0, 4'h0};
    vecs[5]  = '{1'b0, 3'b010, 32'h102, 32'h0,        32'hBABE8765, 1'b0, 2, 4'h0, 4'h0};
    vecs[6]  = '{1'b0, 3'b000, 32'h104, 32'h0,        32'hFFFFFFBE, 1'b0, 1, 4'h0, 4'h0};
    vecs[7]  = '{1'b0, 3'b001, 32'h106, 32'h0,        32'hFFFFCAFE, 1'b0, 1, 4'h0, 4'h0};
    vecs[8]  = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h00000000, 1'b1, 0, 4'h0, 4'h0};
    vecs[9]  = '{1'b0, 3'b111, 32'h100, 32'h0,        32'h00000000, 1'b1, 0, 4'h0, 4'h0};
    vecs[10] = '{1'b1, 3'b010, 32'h102, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 4'hC, 4'h3};
    vecs[11] = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hBEEF4321, 1'b0, 1, 4'h0, 4'h0};
    vecs[12] = '{1'b0, 3'b010, 32'h104, 32'h0,        32'hCAFEDEAD, 1'b0, 1, 4'h0, 4'h0};
    vecs[13] = '{1'b1, 3'b000, 32'h107, 32'hFFFFFF5A, 32'h00000000, 1'b0, 1, 4'h8, 4'h0};
    vecs[14] = '{1'b1, 3'b001, 32'h105, 32'h00001234, 32'h00000000, 1'b0, 1, 4'h6, 4'h0};
    vecs[15] = '{1'b0, 3'b010, 32'h104, 32'h0,        32'h5A1234AD, 1'b0, 1, 4'h0, 4'h0};
    vecs[16] = '{1'b1, 3'b001, 32'h103, 32'h0000ABCD, 32'h00000000, 1'b0, 2, 4'h8, 4'h1};
    vecs[17] = '{1'b0, 3'b101, 32'h103, 32'h0,        32'h0000ABCD, 1'b0, 2, 4'h0, 4'h0};

    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_funct3 = '0;
    bus0.req_addr = '0; bus0.req_wr_data = '0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_funct3 = '0;
    bus1.req_addr = '0; bus1.req_wr_data = '0; bus1.mem_ack = 1'b0; bus1.mem_rd_data = '0;
    bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_funct3 = '0;
    bus2.req_addr = '0; bus2.req_wr_data = '0; bus2.mem_ack = 1'b0; bus2.mem_rd_data = '0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready",  bus0.req_ready,   0);
    chk("rst_resp_valid", bus0.resp_valid,  0);
    chk("rst_resp_error", bus0.resp_error,  0);
    chk("rst_mem_req",    bus0.mem_req,     0);
    chk("rst_mem_wr_ena", bus0.mem_wr_ena,  0);
    chk("rst_mem_addr",   bus0.mem_addr,    0);
    chk("rst_mem_strb",   bus0.mem_wr_strb, 0);
    chk("rst_mem_wdata",  bus0.mem_wr_data, 0);
    chk("rst_resp_data",  bus0.resp_data,   0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus0.req_ready, 1);

    for (int i = 0; i < 18; i++) begin
      log_q.delete();
      req0(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd, d, e, lat, hist);
      chk($sformatf("v%0d_done", i), lat > 0, 1);
      chk($sformatf("v%0d_data", i), d, vecs[i].exp_d);
      chk($sformatf("v%0d_err", i), e, vecs[i].exp_e);
      chk($sformatf("v%0d_ntx", i), 64'(log_q.size()), 64'(vecs[i].ntx));
      if (vecs[i].ntx > 0 && log_q.size() > 0) begin
        chk($sformatf("v%0d_addr0", i), log_q[0].addr, vecs[i].addr & ~32'h3);
        chk($sformatf("v%0d_strb0", i), log_q[0].strb, vecs[i].s0);
      end
      if (vecs[i].ntx > 1 && log_q.size() > 1) begin
        chk($sformatf("v%0d_addr1", i), log_q[1].addr, (vecs[i].addr & ~32'h3) + 32'h4);
        chk($sformatf("v%0d_strb1", i), log_q[1].strb, vecs[i].s1);
      end
    end

    // Zero-latency memory: aligned response two cycles after accept; a split
    // access shows mem_req low for one cycle between its halves.
    lat0 = 1'b1;
    req0(1'b0, 3'b010, 32'h100, 32'h0, d, e, lat, hist);
    chk("aligned_latency", lat, 2);
    chk("aligned_data", d, 32'hCDEF4321);
    req0(1'b0, 3'b101, 32'h103, 32'h0, d, e, lat, hist);
    chk("split_latency", lat, 4);
    chk("split_mem_req_gap", hist[4:1], 4'b0101);
    chk("split_data", d, 32'h0000ABCD);
    lat0 = 1'b0;

    // Ack withheld: error on the 17th cycle after accept, mem_req high throughout.
    auto_mem = 1'b0; m_ack = 1'b0;
    req0(1'b0, 3'b010, 32'h100, 32'h0, d, e, lat, hist);
    chk("timeout_latency", lat, 17);
    chk("timeout_error", e, 1);
    chk("timeout_data", d, 0);
    chk("timeout_mem_req", hist[15:1], 15'h7FFF);

    // ena low with ack held: everything freezes until ena returns.
    bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_funct3 = 3'b010; bus0.req_addr = 32'h100;
    @(negedge clk);
    bus0.req_valid = 1'b0;
    chk("ena_acc0_req", bus0.mem_req, 1);
    m_rd = 32'h11223344; m_ack = 1'b1; ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ena_hold%0d_req", k), bus0.mem_req, 1);
      chk($sformatf("ena_hold%0d_valid", k), bus0.resp_valid, 0);
      chk($sformatf("ena_hold%0d_addr", k), bus0.mem_addr, 32'h100);
    end
    ena = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    chk("ena_resume_valid", bus0.resp_valid, 1);
    chk("ena_resume_data", bus0.resp_data, 32'h11223344);
    @(negedge clk);
    chk("resp_pulse_one_cycle", bus0.resp_valid, 0);
    chk("ready_after_resp", bus0.req_ready, 1);

    // Reset in the second half of a split access drops mem_req immediately.
    bus0.req_valid = 1'b1; bus0.req_funct3 = 3'b101; bus0.req_addr = 32'h103;
    @(negedge clk);
    bus0.req_valid = 1'b0; m_rd = 32'h87654321; m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    chk("rstmid_gap", bus0.mem_req, 0);
    @(negedge clk);
    chk("rstmid_acc1_req", bus0.mem_req, 1);
    chk("rstmid_acc1_addr", bus0.mem_addr, 32'h104);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_mem_req", bus0.mem_req, 0);
    chk("rstmid_addr", bus0.mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_idle", bus0.req_ready, 1);
    auto_mem = 1'b1;
    req0(1'b0, 3'b010, 32'h100, 32'h0, d, e, lat, hist);
    chk("recover_data", d, 32'hCDEF4321);

    // SPLIT_MISALIGNED=0 instance.
    bus1.req_valid = 1'b1; bus1.req_funct3 = 3'b010; bus1.req_addr = 32'h101;
    @(negedge clk);
    bus1.req_valid = 1'b0;
    chk("nosplit_valid", bus1.resp_valid, 1);
    chk("nosplit_error", bus1.resp_error, 1);
    chk("nosplit_data", bus1.resp_data, 0);
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_funct3 = 3'b011; bus1.req_addr = 32'h100;
    @(negedge clk);
    bus1.req_valid = 1'b0;
    chk("f3_011_x32_error", bus1.resp_error, 1);
    @(negedge clk);
    chk("nosplit_no_mem_req", saw1, 0);
    bus1.req_valid = 1'b1; bus1.req_funct3 = 3'b000; bus1.req_addr = 32'h103;
    @(negedge clk);
    bus1.req_valid = 1'b0;
    chk("nosplit_lb_req", bus1.mem_req, 1);
    bus1.mem_rd_data = 32'h87654321; bus1.mem_ack = 1'b1;
    @(negedge clk);
    bus1.mem_ack = 1'b0;
    chk("nosplit_lb_valid", bus1.resp_valid, 1);
    chk("nosplit_lb_error", bus1.resp_error, 0);
    chk("nosplit_lb_data", bus1.resp_data, 32'hFFFFFF87);
    @(negedge clk);

    // XLEN=64 instance: LD 0x104 splits; LWU/LW stay within one word.
    bus2.req_valid = 1'b1; bus2.req_funct3 = 3'b011; bus2.req_addr = 64'h104;
    @(negedge clk);
    bus2.req_valid = 1'b0;
    chk("x64_ld_addr0", bus2.mem_addr, 64'h100);
    bus2.mem_rd_data = 64'hCAFEBABE_87654321; bus2.mem_ack = 1'b1;
    @(negedge clk);
    bus2.mem_ack = 1'b0;
    chk("x64_ld_gap", bus2.mem_req, 0);
    @(negedge clk);
    chk("x64_ld_req1", bus2.mem_req, 1);
    chk("x64_ld_addr1", bus2.mem_addr, 64'h108);
    bus2.mem_rd_data = 64'h0BADF00D_12345678; bus2.mem_ack = 1'b1;
    @(negedge clk);
    bus2.mem_ack = 1'b0;
    chk("x64_ld_valid", bus2.resp_valid, 1);
    chk("x64_ld_data", bus2.resp_data, 64'h12345678_CAFEBABE);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus2.req_valid = 1'b1; bus2.req_funct3 = (k == 0) ? 3'b110 : 3'b010; bus2.req_addr = 64'h104;
      @(negedge clk);
      bus2.req_valid = 1'b0;
      bus2.mem_rd_data = 64'hCAFEBABE_87654321; bus2.mem_ack = 1'b1;
      @(negedge clk);
      bus2.mem_ack = 1'b0;
      chk($sformatf("x64_w%0d_valid", k), bus2.resp_valid, 1);
      chk($sformatf("x64_w%0d_data", k), bus2.resp_data,
          (k == 0) ? 64'h00000000_CAFEBABE : 64'hFFFFFFFF_CAFEBABE);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
